led_pattern_gen: RTL and testbench
==================================

LED_PATTERN_GEN -- requirements
Module: led_pattern_gen

Interface
REQ-001 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-002 Parameter N_LEDS, default 16: number of LED outputs, legal range 4..32.
REQ-003 Parameter TICK_SHIFT_MAX, default 26: log2 of the tick period at speed 0, minimum 16.
REQ-004 Parameter DEB_CYCLES, default 1_000_000: button-stable cycles required before a press is accepted.
REQ-005 Parameter SPEED_INIT, default 8: speed level loaded at reset, range 0..15.
REQ-006 Port clk, input, 1: system clock, 100 MHz on the board.
REQ-007 Port reset_n, input, 1: asynchronous active-low reset.
REQ-008 Port up, input, 1: raw push button that raises the speed.
REQ-009 Port down, input, 1: raw push button that lowers the speed.
REQ-010 Port mode, input, 2: pattern select, where 0=BIN, 1=ROTATE, 2=BOUNCE and 3=BLINK.
REQ-011 Port enable, input, 1: when high, pattern advance is allowed; when low, the pattern freezes.
REQ-012 Port led, output, N_LEDS: registered LED drive.
REQ-013 Port speed, output, 4: current speed level, registered.

Function
REQ-014 up and down SHALL each pass through a 2-FF synchroniser and then a debouncer; the debounced level SHALL change only after the input has been stable for DEB_CYCLES consecutive cycles.
REQ-015 A debounced rising edge SHALL produce exactly one single-cycle press pulse per press.
REQ-016 An up pulse SHALL increment speed, saturating at 15; a down pulse SHALL decrement speed, saturating at 0; simultaneous up and down pulses SHALL leave speed unchanged.
REQ-017 The prescaler SHALL count clk cycles and assert tick for one cycle when it reaches 2^(TICK_SHIFT_MAX-speed)-1, then wrap to 0.
REQ-018 Any change of speed or mode SHALL clear the prescaler in the same cycle, so the first tick after the change arrives a full period later.
REQ-019 While enable=0, the prescaler and pattern state SHALL hold, and led SHALL keep its value.
REQ-020 BIN mode: an N_LEDS-bit step counter SHALL increment on each tick and wrap from all-ones to 0; led = step counter.
REQ-021 ROTATE mode: pos SHALL increment on each tick and wrap from N_LEDS-1 to 0; led = one-hot(pos).
REQ-022 BOUNCE mode: pos SHALL move by 1 in direction dir on each tick; dir SHALL flip when pos reaches N_LEDS-1 or 0, with no double dwell at either end (sequence ...,N-2,N-1,N-2,...); led = one-hot(pos).
REQ-023 BLINK mode: a phase bit SHALL toggle on each tick; led = all ones when phase=1, else all zeros.
REQ-024 On a mode change, the pattern state SHALL reload its initial value (step=0, pos=0, dir=up, phase=0) in the cycle after mode changes.
REQ-025 led SHALL be registered, showing the new pattern one cycle after the tick or state reload.
REQ-026 The speed output SHALL update one cycle after the press pulse.

Reset
REQ-027 While reset_n=0, led SHALL be 0 and speed SHALL be SPEED_INIT.
REQ-028 While reset_n=0, the prescaler, step, pos, phase, synchronisers and debouncers SHALL be 0, and dir SHALL be up.
REQ-029 A reset assertion mid-pattern SHALL take effect immediately and asynchronously, and SHALL override any pending press or tick.
REQ-030 Deassertion SHALL be synchronous to clk; the first tick SHALL occur 2^(TICK_SHIFT_MAX-SPEED_INIT) cycles after deassertion.

Structure
REQ-031 Package led_pattern_pkg SHALL hold the mode_e enum (BIN, ROTATE, BOUNCE, BLINK) and the constants SPEED_MAX=15 and SPEED_W=4.
REQ-032 Sub-module btn_debounce (parameter DEB_CYCLES) SHALL contain the synchroniser, stability counter and press pulse generation, and SHALL be instantiated twice.
REQ-033 The prescaler, speed register, pattern state and output register SHALL reside in led_pattern_gen.

Verification
REQ-034 All scenarios SHALL use N_LEDS=8, TICK_SHIFT_MAX=16, DEB_CYCLES=4 and SPEED_INIT=15, giving a tick every 2 cycles.
REQ-035 Scenario: reset, then mode=1 and enable=1 -> led steps 01,02,04,...,80,01, one step every 2 cycles.
REQ-036 Scenario: mode=2, run 20 ticks -> led sequence 01,02,...,80,40,...,01,02, with 80 and 01 each appearing once per turn.
REQ-037 Scenario: up held for 10 cycles at speed 15 -> speed stays 15; then down held for 10 cycles -> speed=14 and tick period=4.
REQ-038 Scenario: down pulses 3 cycles long (shorter than DEB_CYCLES) -> speed unchanged; up and down pressed in the same cycle -> speed unchanged.
REQ-039 Scenario: mode=0, enable dropped after led=05 for 10 cycles -> led holds 05; after re-enable -> led=06 on the next tick.
REQ-040 Scenario: reset_n pulsed low mid-BOUNCE at led=20 -> led=00 and speed=15 immediately; after release, the mode=2 pattern restarts at 01.

Source files
------------

// File: rtl/led_pattern_pkg.sv
// Shared types and constants for the LED pattern generator.
package led_pattern_pkg;

   typedef enum logic [1:0] {
      BIN    = 2'd0,
      ROTATE = 2'd1,
      BOUNCE = 2'd2,
      BLINK  = 2'd3
   } mode_e;

   typedef enum logic {
      DIR_DOWN = 1'b0,
      DIR_UP   = 1'b1
   } dir_e;

   localparam int unsigned SPEED_W = 4;
   localparam logic [SPEED_W-1:0] SPEED_MAX = 4'd15;

endpackage

// File: rtl/btn_debounce.sv
// Push-button conditioner: 2-FF synchroniser, stability counter and
// single-cycle press pulse on each accepted rising edge.
module btn_debounce #(
   parameter int unsigned DEB_CYCLES = 1_000_000
) (
   input  logic clk,
   input  logic reset_n,
   input  logic raw,
   output logic press
);

   localparam int unsigned CNT_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES + 1) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

   logic             sync_1;
   logic             sync_2;
   logic             level;
   logic [CNT_W-1:0] cnt;
   logic             accept;

   // The counter tracks how long the synchronised input has disagreed with
   // the accepted level; any agreement restarts the stability window.
   assign accept = (sync_2 != level) && (cnt == CNT_LAST);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync_1 <= 1'b0;
         sync_2 <= 1'b0;
         level  <= 1'b0;
         cnt    <= '0;
         press  <= 1'b0;
      end else begin
         sync_1 <= raw;
         sync_2 <= sync_1;
         press  <= accept && sync_2;
         if (sync_2 == level) begin
            cnt <= '0;
         end else if (accept) begin
            level <= sync_2;
            cnt   <= '0;
         end else begin
            cnt <= cnt + CNT_W'(1);
         end
      end
   end

endmodule

// File: rtl/led_pattern_gen.sv
// LED pattern generator: debounced speed control, speed-dependent tick
// prescaler and four selectable LED patterns with a registered output.
module led_pattern_gen
   import led_pattern_pkg::*;
#(
   parameter int unsigned N_LEDS         = 16,
   parameter int unsigned TICK_SHIFT_MAX = 26,
   parameter int unsigned DEB_CYCLES     = 1_000_000,
   parameter int unsigned SPEED_INIT     = 8
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               up,
   input  logic               down,
   input  logic [1:0]         mode,
   input  logic               enable,
   output logic [N_LEDS-1:0]  led,
   output logic [SPEED_W-1:0] speed
);

   localparam int unsigned POS_W = $clog2(N_LEDS);
   localparam logic [POS_W-1:0] POS_LAST = POS_W'(N_LEDS - 1);
   localparam logic [POS_W-1:0] POS_PEN  = POS_W'(N_LEDS - 2);
   localparam logic [POS_W-1:0] POS_ONE  = POS_W'(1);

   logic                      up_press;
   logic                      down_press;
   logic [SPEED_W-1:0]        speed_next;
   logic                      speed_chg;
   mode_e                     mode_in;
   mode_e                     mode_q;
   logic                      mode_chg;
   logic                      clr;
   logic [31:0]               shift;
   logic [TICK_SHIFT_MAX-1:0] limit;
   logic [TICK_SHIFT_MAX-1:0] cnt;
   logic                      tick;
   logic [N_LEDS-1:0]         step;
   logic [N_LEDS-1:0]         step_n;
   logic [POS_W-1:0]          pos;
   logic [POS_W-1:0]          pos_n;
   dir_e                      dir;
   dir_e                      dir_n;
   logic                      phase;
   logic                      phase_n;
   logic [N_LEDS-1:0]         led_n;

   btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_up_deb (
      .clk     (clk),
      .reset_n (reset_n),
      .raw     (up),
      .press   (up_press)
   );

   btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_down_deb (
      .clk     (clk),
      .reset_n (reset_n),
      .raw     (down),
      .press   (down_press)
   );

   assign mode_in  = mode_e'(mode);
   assign mode_chg = (mode_in != mode_q);
   assign speed_chg = (speed_next != speed);
   assign clr      = speed_chg || mode_chg;

   always_comb begin
      speed_next = speed;
      if (up_press && !down_press && speed != SPEED_MAX) begin
         speed_next = speed + SPEED_W'(1);
      end else if (down_press && !up_press && speed != '0) begin
         speed_next = speed - SPEED_W'(1);
      end
   end

   // Terminal count 2^(TICK_SHIFT_MAX-speed)-1 as a low-bit mask; a shift
   // of the full width yields the all-ones count for speed 0.
   always_comb begin
      shift = TICK_SHIFT_MAX - 32'(speed);
      limit = ~({TICK_SHIFT_MAX{1'b1}} << shift);
   end

   assign tick = enable && (cnt == limit) && !clr;

   always_comb begin
      step_n  = step;
      pos_n   = pos;
      dir_n   = dir;
      phase_n = phase;
      if (mode_chg) begin
         step_n  = '0;
         pos_n   = '0;
         dir_n   = DIR_UP;
         phase_n = 1'b0;
      end else if (tick) begin
         case (mode_q)
            BIN:    step_n = step + N_LEDS'(1);
            ROTATE: pos_n = (pos == POS_LAST) ? '0 : pos + POS_ONE;
            BOUNCE: begin
               // Direction flips on arrival at an end so neither end dwells.
               if (dir == DIR_UP) begin
                  pos_n = pos + POS_ONE;
                  if (pos == POS_PEN) dir_n = DIR_DOWN;
               end else begin
                  pos_n = pos - POS_ONE;
                  if (pos == POS_ONE) dir_n = DIR_UP;
               end
            end
            BLINK:  phase_n = ~phase;
         endcase
      end
   end

   always_comb begin
      led_n = '0;
      case (mode_in)
         BIN:           led_n = step_n;
         ROTATE, BOUNCE: led_n = N_LEDS'(1) << pos_n;
         BLINK:         led_n = {N_LEDS{phase_n}};
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         speed  <= SPEED_W'(SPEED_INIT);
         mode_q <= BIN;
         cnt    <= '0;
         step   <= '0;
         pos    <= '0;
         dir    <= DIR_UP;
         phase  <= 1'b0;
         led    <= '0;
      end else begin
         speed  <= speed_next;
         mode_q <= mode_in;
         if (clr) begin
            cnt <= '0;
         end else if (enable) begin
            cnt <= (cnt == limit) ? '0 : cnt + TICK_SHIFT_MAX'(1);
         end
         step  <= step_n;
         pos   <= pos_n;
         dir   <= dir_n;
         phase <= phase_n;
         led   <= led_n;
      end
   end

endmodule

// File: tb/tb_led_pattern_gen.sv
// Bench for led_pattern_gen: directed scenarios plus randomized buttons,
// modes, enable and resets against a tick-count based reference model.
module tb_led_pattern_gen;

   localparam int unsigned N     = 8;
   localparam int unsigned TSM   = 16;
   localparam int unsigned DEB   = 4;
   localparam int unsigned SINIT = 15;

   logic         clk = 1'b0;
   logic         reset_n;
   logic         up;
   logic         down;
   logic [1:0]   mode;
   logic         enable;
   logic [N-1:0] led;
   logic [3:0]   speed;

   int unsigned n_checks = 0;
   int unsigned n_errors = 0;

   always #5 clk = ~clk;

   led_pattern_gen #(
      .N_LEDS         (N),
      .TICK_SHIFT_MAX (TSM),
      .DEB_CYCLES     (DEB),
      .SPEED_INIT     (SINIT)
   ) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .up      (up),
      .down    (down),
      .mode    (mode),
      .enable  (enable),
      .led     (led),
      .speed   (speed)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference model: raw-sample windows for the buttons, and the LED value
   // derived in closed form from the number of ticks since the last restart.
   bit           hist_up[$];
   bit           hist_dn[$];
   bit           lvl_up, lvl_dn, pls_up, pls_dn;
   int unsigned  m_speed, m_cnt, m_ticks;
   logic [1:0]   m_mode;
   logic [N-1:0] m_led;

   function automatic logic [N-1:0] pattern(input logic [1:0] md, input int unsigned k);
      int unsigned m;
      case (md)
         2'd0: return N'(k);
         2'd1: return N'(1) << (k % N);
         2'd2: begin
            m = k % (2 * N - 2);
            return N'(1) << ((m < N) ? m : (2 * N - 2 - m));
         end
         default: return (k % 2 == 1) ? '1 : '0;
      endcase
   endfunction

   function automatic bit accepted(input bit q[$], input bit lvl);
      for (int i = 2; i < DEB + 2; i++) if (q[i] == lvl) return 1'b0;
      return 1'b1;
   endfunction

   task automatic model_reset();
      hist_up.delete();
      hist_dn.delete();
      for (int i = 0; i < DEB + 2; i++) begin
         hist_up.push_back(1'b0);
         hist_dn.push_back(1'b0);
      end
      lvl_up = 0; lvl_dn = 0; pls_up = 0; pls_dn = 0;
      m_speed = SINIT; m_cnt = 0; m_ticks = 0; m_mode = 2'd0; m_led = '0;
   endtask

   task automatic model_edge();
      bit acc_up, acc_dn;
      int unsigned new_speed;
      if (!reset_n) begin
         model_reset();
         return;
      end
      hist_up.push_front(up);   void'(hist_up.pop_back());
      hist_dn.push_front(down); void'(hist_dn.pop_back());
      acc_up = accepted(hist_up, lvl_up);
      acc_dn = accepted(hist_dn, lvl_dn);
      new_speed = m_speed;
      if (pls_up && !pls_dn && m_speed < 15) new_speed = m_speed + 1;
      else if (pls_dn && !pls_up && m_speed > 0) new_speed = m_speed - 1;
      if (mode != m_mode) begin
         m_ticks = 0;
         m_cnt   = 0;
      end else if (new_speed != m_speed) begin
         m_cnt = 0;
      end else if (enable) begin
         m_cnt++;
         if (m_cnt == (1 << (TSM - m_speed))) begin
            m_cnt = 0;
            m_ticks++;
         end
      end
      pls_up = acc_up && !lvl_up;
      pls_dn = acc_dn && !lvl_dn;
      if (acc_up) lvl_up = !lvl_up;
      if (acc_dn) lvl_dn = !lvl_dn;
      m_speed = new_speed;
      m_mode  = mode;
      m_led   = pattern(mode, m_ticks);
   endtask

   task automatic cyc();
      @(posedge clk);
      model_edge();
      #1;
      check("led", led, m_led);
      check("speed", speed, m_speed);
   endtask

   task automatic run(input int unsigned n);
      repeat (n) cyc();
   endtask

   task automatic run_until(input logic [N-1:0] v, input int unsigned lim, input string tag);
      for (int unsigned i = 0; i < lim && led !== v; i++) cyc();
      check(tag, led, v);
   endtask

   task automatic wait_change(output int unsigned n);
      logic [N-1:0] l0;
      l0 = led;
      n = 0;
      while (led === l0 && n < 200) begin
         cyc();
         n++;
      end
   endtask

   task automatic async_reset();
      #2 reset_n = 1'b0;
      #1;
      check("async_rst_led", led, 0);
      check("async_rst_speed", speed, SINIT);
      model_reset();
      cyc();
      reset_n = 1'b1;
   endtask

   logic [N-1:0] bounce_seq [21] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
                                    8'h80, 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02,
                                    8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40};

   initial begin
      int unsigned n;
      int unsigned up_hold, dn_hold;
      reset_n = 1'b0; up = 0; down = 0; mode = 2'd0; enable = 0;
      model_reset();
      #3;
      run(2);
      check("rst_led", led, 0);
      check("rst_speed", speed, SINIT);
      reset_n = 1'b1;
      run(3);

      // ROTATE: 01,02,...,80,01 one step every 2 cycles
      mode = 2'd1; enable = 1'b1;
      cyc();
      check("rotate_start", led, 8'h01);
      for (int unsigned s = 1; s <= 8; s++) begin
         run(2);
         check("rotate", led, 8'h01 << (s % 8));
      end

      // BOUNCE: single dwell at each end
      mode = 2'd2;
      cyc();
      check("bounce_start", led, bounce_seq[0]);
      for (int unsigned s = 1; s <= 20; s++) begin
         run(2);
         check("bounce", led, bounce_seq[s]);
      end

      // Saturation at 15, then one step down and a longer tick period
      up = 1'b1; run(10); up = 1'b0; run(6);
      check("speed_sat_hi", speed, 15);
      down = 1'b1; run(10); down = 1'b0; run(6);
      check("speed_dec", speed, 14);
      wait_change(n);
      wait_change(n);
      check("period_14", n, 4);

      // Short glitches are rejected; simultaneous presses cancel
      repeat (3) begin
         down = 1'b1; run(3); down = 1'b0; run(6);
      end
      check("glitch_reject", speed, 14);
      up = 1'b1; down = 1'b1; run(10); up = 1'b0; down = 1'b0; run(6);
      check("both_pressed", speed, 14);

      // BIN with enable hold
      mode = 2'd0;
      cyc();
      check("bin_start", led, 0);
      run_until(8'h05, 100, "bin_reach_05");
      enable = 1'b0;
      run(10);
      check("bin_hold", led, 8'h05);
      enable = 1'b1;
      wait_change(n);
      check("bin_resume", led, 8'h06);

      // Reset mid-BOUNCE
      mode = 2'd2;
      run_until(8'h20, 200, "bounce_reach_20");
      async_reset();
      cyc();
      check("restart_led", led, 8'h01);
      check("restart_speed", speed, SINIT);

      // BLINK smoke test before random traffic
      mode = 2'd3;
      run(12);

      up_hold = 0;
      dn_hold = 0;
      repeat (4000) begin
         if (up_hold == 0 && $urandom_range(0, 19) == 0) up_hold = $urandom_range(1, 10);
         if (dn_hold == 0 && $urandom_range(0, 29) == 0) dn_hold = $urandom_range(1, 10);
         up   = (up_hold != 0);
         down = (dn_hold != 0);
         if (up_hold != 0) up_hold--;
         if (dn_hold != 0) dn_hold--;
         if ($urandom_range(0, 149) == 0) mode = 2'($urandom_range(0, 3));
         if ($urandom_range(0, 39) == 0) enable = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 999) == 0) async_reset();
         cyc();
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
